// File: rtl/acq_scheduler_pkg.sv
// Shared types and widths for the acquisition scheduler: channel mode
// encodings (common with the per-channel acquisition controller), FSM
// states and result field widths.
package acq_scheduler_pkg;

  localparam int unsigned MODE_WIDTH        = 2;
  localparam int unsigned I2Q2_WIDTH        = 32;
  localparam int unsigned DOPPLER_INC_WIDTH = 16;
  localparam int unsigned CS_WIDTH          = 11;

  // A released channel must sit idle this many cycles so the acquisition
  // controller sees a fresh transition into MODE_ACQ.
  localparam logic [1:0] IDLE_SETTLE = 2'd2;

  typedef enum logic [MODE_WIDTH-1:0] {
    MODE_IDLE  = 2'd0,
    MODE_ACQ   = 2'd1,
    MODE_TRACK = 2'd2
  } ch_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_EVAL   = 2'd2,
    ST_ASSIGN = 2'd3
  } sched_state_e;

  // Index width that stays at least 1 bit for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acq_scheduler_rr_pick.sv
// rr_pick: round-robin one-hot selector over a request vector. The search
// starts one position after the last granted index, which is held in a
// register and updated only when the grant is consumed.
module rr_pick import acq_scheduler_pkg::*; #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               global_reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_vec,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] cand;

  // Search requesters in circular order starting after the last grant.
  always_comb begin
    grant_vec = '0;
    grant_idx = last_q;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  // Remember the consumed grant as the new round-robin origin.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      last_q <= '0;
    end else if (advance && grant_any) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/acq_scheduler.sv
// acq_scheduler: assigns eligible PRNs to idle channels, starts acquisition,
// and on completion either hands the channel to tracking (peak above
// threshold) or releases channel and PRN for another attempt.
// Optional feature macro: ACQ_SCHED_RETRY_LIMIT_EN parks a PRN after
// RETRY_LIMIT consecutive failed acquisitions.
module acq_scheduler import acq_scheduler_pkg::*; #(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned NUM_PRN     = 32,
  parameter  int unsigned RETRY_LIMIT = 3,
  localparam int unsigned PRN_WIDTH   = idx_width(NUM_PRN)
) (
  input  logic                                clk,
  input  logic                                global_reset_n,
  input  logic                                enable,
  input  logic [NUM_PRN-1:0]                  prn_enable,
  input  logic [I2Q2_WIDTH-1:0]               acq_threshold,
  output logic [NUM_CH*MODE_WIDTH-1:0]        ch_mode,
  output logic [NUM_CH*PRN_WIDTH-1:0]         ch_prn,
  input  logic [NUM_CH-1:0]                   ch_acq_complete,
  input  logic [NUM_CH*I2Q2_WIDTH-1:0]        ch_peak_i2q2,
  input  logic [NUM_CH*DOPPLER_INC_WIDTH-1:0] ch_peak_doppler,
  input  logic [NUM_CH*CS_WIDTH-1:0]          ch_peak_code_shift,
  input  logic [NUM_CH-1:0]                   ch_lock_lost,
  output logic [NUM_CH-1:0]                   ch_init_valid,
  output logic [DOPPLER_INC_WIDTH-1:0]        init_doppler,
  output logic [CS_WIDTH-1:0]                 init_code_shift,
  output logic [NUM_PRN-1:0]                  prn_assigned
);

  localparam int unsigned CH_IDX_W = idx_width(NUM_CH);

  sched_state_e           state_q;
  ch_mode_e               mode_q [NUM_CH];
  logic [PRN_WIDTH-1:0]   prn_q  [NUM_CH];
  logic [1:0]             age_q  [NUM_CH];

  logic [NUM_CH-1:0]      pending_q, cmpl_d, cmpl_rise, release_v, rr_req;
  logic [NUM_CH-1:0]      eval_sel_q, rr_grant_vec;
  logic [NUM_PRN-1:0]     prn_en_d, prn_fall, parked;
  logic [PRN_WIDTH-1:0]   prn_ptr_q, asg_prn_q, ptr_inc, eval_prn, fail_ptr;
  logic [CH_IDX_W-1:0]    eval_ch_q, asg_ch_q, idle_idx, rr_idx;
  logic                   idle_any, scan_ok, eval_live, eval_pass, rr_any;
  logic [I2Q2_WIDTH-1:0]        peak_sel;
  logic [DOPPLER_INC_WIDTH-1:0] dop_sel;
  logic [CS_WIDTH-1:0]          cs_sel;

  assign cmpl_rise = ch_acq_complete & ~cmpl_d;
  assign prn_fall  = prn_en_d & ~prn_enable;
  assign rr_req    = pending_q & ~release_v;

`ifdef ACQ_SCHED_RETRY_LIMIT_EN
  localparam int unsigned CNT_W = idx_width(RETRY_LIMIT + 1);
  logic [CNT_W-1:0] fail_cnt_q [NUM_PRN];

  // A PRN is parked once its consecutive-failure count reaches the limit.
  always_comb begin
    parked = '0;
    for (int unsigned p = 0; p < NUM_PRN; p++)
      parked[p] = (fail_cnt_q[p] >= CNT_W'(RETRY_LIMIT));
  end
`else
  assign parked = '0;
`endif

  // Pending channels are served round-robin after the last evaluated one.
  rr_pick #(
    .NUM_REQ (NUM_CH)
  ) u_rr_pick (
    .clk            (clk),
    .global_reset_n (global_reset_n),
    .req            (rr_req),
    .advance        (enable && (state_q == ST_SCAN)),
    .grant_vec      (rr_grant_vec),
    .grant_idx      (rr_idx),
    .grant_any      (rr_any)
  );

  // Pack per-channel mode and PRN registers onto the flat output buses.
  always_comb begin
    ch_mode = '0;
    ch_prn  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch_mode[c*MODE_WIDTH +: MODE_WIDTH] = mode_q[c];
      ch_prn[c*PRN_WIDTH +: PRN_WIDTH]    = prn_q[c];
    end
  end

  // Per-channel release requests and lowest-index settled idle channel.
  always_comb begin
    release_v = '0;
    idle_any  = 1'b0;
    idle_idx  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      release_v[c] = ((mode_q[c] == MODE_TRACK) && ch_lock_lost[c]) ||
                     ((mode_q[c] != MODE_IDLE) && prn_fall[prn_q[c]]);
      if (!idle_any && (mode_q[c] == MODE_IDLE) && (age_q[c] == IDLE_SETTLE)) begin
        idle_any = 1'b1;
        idle_idx = CH_IDX_W'(c);
      end
    end
  end

  // Select the result fields of the channel under evaluation.
  always_comb begin
    peak_sel = '0;
    dop_sel  = '0;
    cs_sel   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (CH_IDX_W'(c) == eval_ch_q) begin
        peak_sel = ch_peak_i2q2[c*I2Q2_WIDTH +: I2Q2_WIDTH];
        dop_sel  = ch_peak_doppler[c*DOPPLER_INC_WIDTH +: DOPPLER_INC_WIDTH];
        cs_sel   = ch_peak_code_shift[c*CS_WIDTH +: CS_WIDTH];
      end
    end
  end

  // PRN pointer arithmetic and scan/eval qualifiers.
  always_comb begin
    ptr_inc   = (prn_ptr_q == PRN_WIDTH'(NUM_PRN - 1)) ? '0 : prn_ptr_q + PRN_WIDTH'(1);
    eval_prn  = prn_q[eval_ch_q];
    fail_ptr  = (eval_prn == PRN_WIDTH'(NUM_PRN - 1)) ? '0 : eval_prn + PRN_WIDTH'(1);
    scan_ok   = prn_enable[prn_ptr_q] && !prn_assigned[prn_ptr_q] && !parked[prn_ptr_q];
    eval_live = (mode_q[eval_ch_q] == MODE_ACQ) && !release_v[eval_ch_q];
    eval_pass = (peak_sel > acq_threshold);
  end

  // Edge-detect history and per-channel idle age (saturates at the settle count).
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      cmpl_d   <= '0;
      prn_en_d <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) age_q[c] <= '0;
    end else begin
      cmpl_d   <= ch_acq_complete;
      prn_en_d <= prn_enable;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (mode_q[c] != MODE_IDLE)    age_q[c] <= '0;
        else if (age_q[c] != IDLE_SETTLE) age_q[c] <= age_q[c] + 2'd1;
      end
    end
  end

  // Scheduler FSM with registered channel modes, PRNs and tracking seed.
  // Releases are applied last so they override EVAL/ASSIGN on the same edge.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q         <= ST_IDLE;
      prn_ptr_q       <= '0;
      eval_ch_q       <= '0;
      eval_sel_q      <= '0;
      asg_ch_q        <= '0;
      asg_prn_q       <= '0;
      pending_q       <= '0;
      prn_assigned    <= '0;
      ch_init_valid   <= '0;
      init_doppler    <= '0;
      init_code_shift <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        mode_q[c] <= MODE_IDLE;
        prn_q[c]  <= '0;
      end
`ifdef ACQ_SCHED_RETRY_LIMIT_EN
      for (int unsigned p = 0; p < NUM_PRN; p++) fail_cnt_q[p] <= '0;
`endif
    end else begin
      ch_init_valid <= '0;
      if (!enable) begin
        state_q      <= ST_IDLE;
        pending_q    <= '0;
        prn_assigned <= '0;
        for (int unsigned c = 0; c < NUM_CH; c++) mode_q[c] <= MODE_IDLE;
`ifdef ACQ_SCHED_RETRY_LIMIT_EN
        for (int unsigned p = 0; p < NUM_PRN; p++) fail_cnt_q[p] <= '0;
`endif
      end else begin
        for (int unsigned c = 0; c < NUM_CH; c++)
          if (cmpl_rise[c] && (mode_q[c] == MODE_ACQ)) pending_q[c] <= 1'b1;

        case (state_q)
          ST_IDLE: state_q <= ST_SCAN;

          ST_SCAN: begin
            if (rr_any) begin
              state_q    <= ST_EVAL;
              eval_ch_q  <= rr_idx;
              eval_sel_q <= rr_grant_vec;
            end else if (!scan_ok) begin
              prn_ptr_q <= ptr_inc;
            end else if (idle_any) begin
              state_q   <= ST_ASSIGN;
              asg_ch_q  <= idle_idx;
              asg_prn_q <= prn_ptr_q;
            end
          end

          ST_EVAL: begin
            state_q <= ST_SCAN;
            for (int unsigned c = 0; c < NUM_CH; c++)
              if (eval_sel_q[c]) pending_q[c] <= 1'b0;
            if (eval_live) begin
              if (eval_pass) begin
                mode_q[eval_ch_q]        <= MODE_TRACK;
                ch_init_valid[eval_ch_q] <= 1'b1;
                init_doppler             <= dop_sel;
                init_code_shift          <= cs_sel;
`ifdef ACQ_SCHED_RETRY_LIMIT_EN
                fail_cnt_q[eval_prn]     <= '0;
`endif
              end else begin
                mode_q[eval_ch_q]      <= MODE_IDLE;
                prn_assigned[eval_prn] <= 1'b0;
                prn_ptr_q              <= fail_ptr;
`ifdef ACQ_SCHED_RETRY_LIMIT_EN
                if (fail_cnt_q[eval_prn] < CNT_W'(RETRY_LIMIT))
                  fail_cnt_q[eval_prn] <= fail_cnt_q[eval_prn] + CNT_W'(1);
`endif
              end
            end
          end

          ST_ASSIGN: begin
            state_q <= ST_SCAN;
            if (prn_enable[asg_prn_q] && !prn_assigned[asg_prn_q] &&
                (mode_q[asg_ch_q] == MODE_IDLE)) begin
              prn_q[asg_ch_q]         <= asg_prn_q;
              mode_q[asg_ch_q]        <= MODE_ACQ;
              prn_assigned[asg_prn_q] <= 1'b1;
            end
          end

          default: state_q <= ST_IDLE;
        endcase

        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (release_v[c]) begin
            mode_q[c]              <= MODE_IDLE;
            pending_q[c]           <= 1'b0;
            prn_assigned[prn_q[c]] <= 1'b0;
          end
        end
`ifdef ACQ_SCHED_RETRY_LIMIT_EN
        for (int unsigned p = 0; p < NUM_PRN; p++)
          if (prn_fall[p]) fail_cnt_q[p] <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_acq_scheduler.sv
// Directed bench for acq_scheduler with two channels and a 32-PRN pool.
module tb_acq_scheduler;
  import acq_scheduler_pkg::*;

  localparam int NCH = 2;
  localparam int NPRN = 32;
  localparam int PW = 5;
  localparam int MW = 2;

  logic                          clk;
  logic                          global_reset_n;
  logic                          enable;
  logic [NPRN-1:0]               prn_enable;
  logic [I2Q2_WIDTH-1:0]         acq_threshold;
  logic [NCH*MW-1:0]             ch_mode;
  logic [NCH*PW-1:0]             ch_prn;
  logic [NCH-1:0]                ch_acq_complete;
  logic [NCH*I2Q2_WIDTH-1:0]     ch_peak_i2q2;
  logic [NCH*DOPPLER_INC_WIDTH-1:0] ch_peak_doppler;
  logic [NCH*CS_WIDTH-1:0]       ch_peak_code_shift;
  logic [NCH-1:0]                ch_lock_lost;
  logic [NCH-1:0]                ch_init_valid;
  logic [DOPPLER_INC_WIDTH-1:0]  init_doppler;
  logic [CS_WIDTH-1:0]           init_code_shift;
  logic [NPRN-1:0]               prn_assigned;

  int n_tests;
  int n_fail;
  int idle_cyc;
  bit ok;

  acq_scheduler #(
    .NUM_CH      (NCH),
    .NUM_PRN     (NPRN),
    .RETRY_LIMIT (3)
  ) dut (
    .clk                (clk),
    .global_reset_n     (global_reset_n),
    .enable             (enable),
    .prn_enable         (prn_enable),
    .acq_threshold      (acq_threshold),
    .ch_mode            (ch_mode),
    .ch_prn             (ch_prn),
    .ch_acq_complete    (ch_acq_complete),
    .ch_peak_i2q2       (ch_peak_i2q2),
    .ch_peak_doppler    (ch_peak_doppler),
    .ch_peak_code_shift (ch_peak_code_shift),
    .ch_lock_lost       (ch_lock_lost),
    .ch_init_valid      (ch_init_valid),
    .init_doppler       (init_doppler),
    .init_code_shift    (init_code_shift),
    .prn_assigned       (prn_assigned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] mode_of(input int ch);
    return ch_mode[ch*MW +: MW];
  endfunction

  function automatic logic [PW-1:0] prn_of(input int ch);
    return ch_prn[ch*PW +: PW];
  endfunction

  // Wait (bounded) until channel ch is in MODE_ACQ with the given PRN,
  // counting sampled cycles where it was idle along the way.
  task automatic wait_acq(input int ch, input int prn, input int budget,
                          output int idle_n, output bit found);
    found  = 1'b0;
    idle_n = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick(1);
      if (mode_of(ch) == MODE_ACQ && prn_of(ch) == PW'(prn)) found = 1'b1;
      else if (mode_of(ch) == MODE_IDLE) idle_n++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    global_reset_n     = 1'b0;
    enable             = 1'b0;
    prn_enable         = '0;
    acq_threshold      = 32'd500;
    ch_acq_complete    = '0;
    ch_peak_i2q2       = '0;
    ch_peak_doppler    = '0;
    ch_peak_code_shift = '0;
    ch_lock_lost       = '0;
    tick(3);
    check("rst_mode", ch_mode, 0);
    check("rst_prn", ch_prn, 0);
    check("rst_iv", ch_init_valid, 0);
    check("rst_dop", init_doppler, 0);
    check("rst_cs", init_code_shift, 0);
    check("rst_assigned", prn_assigned, 0);

    // Phase 1: initial assignment, pass, boundary fail and reassignment
    prn_enable     = 32'h5;
    enable         = 1'b1;
    global_reset_n = 1'b1;
    tick(20);
    check("assign_mode", ch_mode, 5);
    check("assign_prn", ch_prn, 64);
    check("assign_mask", prn_assigned, 5);

    ch_peak_i2q2       = {32'd0, 32'd900};
    ch_peak_doppler    = {16'd0, 16'd1598};
    ch_peak_code_shift = {11'd0, 11'd7};
    ch_acq_complete    = 2'b01;
    tick(2);
    check("pass_pre_mode", ch_mode, 5);
    tick(1);
    check("pass_mode", ch_mode, 6);
    check("pass_iv", ch_init_valid, 1);
    check("pass_dop", init_doppler, 1598);
    check("pass_cs", init_code_shift, 7);
    tick(1);
    check("pass_iv_single", ch_init_valid, 0);

    ch_peak_i2q2    = {32'd500, 32'd900};
    ch_acq_complete = 2'b11;
    tick(2);
    check("fail_pre_mode", ch_mode, 6);
    tick(1);
    check("fail_mode", ch_mode, 2);
    check("fail_iv", ch_init_valid, 0);
    check("fail_mask", prn_assigned, 1);
    ch_acq_complete = 2'b01;
    wait_acq(1, 2, 100, idle_cyc, ok);
    check("reassign_found", ok, 1);
    check("reassign_gap", idle_cyc >= 2, 1);
    check("reassign_mask", prn_assigned, 5);

    // Reset asserted while channel 1 is being evaluated
    ch_peak_i2q2    = {32'd400, 32'd900};
    ch_acq_complete = 2'b11;
    tick(2);
    #2 global_reset_n = 1'b0;
    #1;
    check("midrst_mode", ch_mode, 0);
    check("midrst_prn", ch_prn, 0);
    check("midrst_mask", prn_assigned, 0);
    check("midrst_iv", ch_init_valid, 0);
    check("midrst_dop", init_doppler, 0);
    check("midrst_cs", init_code_shift, 0);
    tick(2);
    check("midrst_hold", ch_mode, 0);

    // Phase 2: simultaneous completion, round-robin order, lock loss
    ch_acq_complete    = 2'b00;
    ch_peak_i2q2       = {32'd900, 32'd900};
    ch_peak_doppler    = {16'd200, 16'd100};
    ch_peak_code_shift = {11'd5, 11'd3};
    global_reset_n     = 1'b1;
    tick(20);
    check("p2_assign_mode", ch_mode, 5);
    ch_acq_complete = 2'b11;
    tick(3);
    check("rr_first_mode", ch_mode, 9);
    check("rr_first_iv", ch_init_valid, 2);
    check("rr_first_dop", init_doppler, 200);
    check("rr_first_cs", init_code_shift, 5);
    tick(2);
    check("rr_second_mode", ch_mode, 10);
    check("rr_second_iv", ch_init_valid, 1);
    check("rr_second_dop", init_doppler, 100);
    check("rr_second_cs", init_code_shift, 3);

    ch_acq_complete = 2'b00;
    ch_lock_lost    = 2'b01;
    tick(1);
    check("lock_mode", ch_mode, 8);
    check("lock_mask", prn_assigned, 4);
    ch_lock_lost = 2'b00;
    wait_acq(0, 0, 100, idle_cyc, ok);
    check("lock_reassign", ok, 1);
    check("lock_reassign_mode", ch_mode, 9);
    ch_lock_lost = 2'b01;
    tick(1);
    check("lock_ignored_acq", ch_mode, 9);
    ch_lock_lost = 2'b00;

    prn_enable = 32'h1;
    tick(1);
    check("prndis_mode", ch_mode, 1);
    check("prndis_mask", prn_assigned, 1);

    enable = 1'b0;
    tick(1);
    check("disable_mode", ch_mode, 0);
    check("disable_mask", prn_assigned, 0);

`ifdef ACQ_SCHED_RETRY_LIMIT_EN
    // PRN 2 parked after three consecutive failures, restored by re-enable
    global_reset_n  = 1'b0;
    tick(1);
    prn_enable      = 32'h5;
    ch_peak_i2q2    = {32'd400, 32'd900};
    ch_acq_complete = 2'b00;
    enable          = 1'b1;
    global_reset_n  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_acq(1, 2, 100, idle_cyc, ok);
      check("retry_acq", ok, 1);
      ch_acq_complete = 2'b10;
      tick(3);
      check("retry_fail", mode_of(1), MODE_IDLE);
      ch_acq_complete = 2'b00;
    end
    tick(80);
    check("parked_mask", prn_assigned, 1);
    check("parked_idle", mode_of(1), MODE_IDLE);
    prn_enable = 32'h1;
    tick(1);
    prn_enable = 32'h5;
    wait_acq(1, 2, 100, idle_cyc, ok);
    check("unpark_acq", ok, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acq_scheduler.md
# acq_scheduler

Sequences the per-channel acquisition controllers in the tracking front end. Holds a pool of eligible PRNs, assigns free PRNs to idle channels, and starts acquisition on those channels. When a channel finishes acquisition, the block compares its peak I2Q2 to a programmable threshold and either hands the channel to tracking with its peak Doppler and code shift, or releases the channel and its PRN for reassignment. It sits between the top-level control registers and the channel array, one instance per receiver.

## Interface
- NUM_CH, 4, number of channels (1–16)
- NUM_PRN, 32, PRN pool size; PRN_WIDTH = clog2(NUM_PRN)
- RETRY_LIMIT, 3, consecutive failed acquisitions before a PRN is parked (only with ACQ_SCHED_RETRY_LIMIT_EN)

- clk  in  1  system clock
- global_reset_n  in  1  asynchronous, active-low reset
- enable  in  1  scheduler run; low forces all channels to MODE_IDLE within 1 cycle
- prn_enable  in  NUM_PRN  PRN eligibility mask
- acq_threshold  in  I2Q2_WIDTH  pass threshold; pass when peak > threshold
- ch_mode  out  NUM_CH*MODE_WIDTH  per-channel mode (MODE_IDLE/MODE_ACQ/MODE_TRACK)
- ch_prn  out  NUM_CH*PRN_WIDTH  PRN assigned to each channel
- ch_acq_complete  in  NUM_CH  per-channel acquisition-complete level
- ch_peak_i2q2  in  NUM_CH*I2Q2_WIDTH  peak result
- ch_peak_doppler  in  NUM_CH*DOPPLER_INC_WIDTH  peak Doppler
- ch_peak_code_shift  in  NUM_CH*CS_WIDTH  peak code shift
- ch_lock_lost  in  NUM_CH  tracking loop lost lock (level)
- ch_init_valid  out  NUM_CH  one-cycle strobe; tracking seed for the flagged channel is on init_*
- init_doppler  out  DOPPLER_INC_WIDTH  tracking seed Doppler
- init_code_shift  out  CS_WIDTH  tracking seed code shift
- prn_assigned  out  NUM_PRN  PRNs currently owned by a channel

## Operation
- The acquisition controller starts on a transition of its mode into MODE_ACQ. The scheduler therefore holds a released channel in MODE_IDLE for at least 2 cycles before reassigning it.
- pending[c] is set on the rising edge of ch_acq_complete[c] while ch_mode[c]==MODE_ACQ. It is cleared when channel c is evaluated.
- FSM states:
  - IDLE: wait for enable.
  - SCAN: default working state.
  - EVAL: resolve one pending channel.
  - ASSIGN: start acquisition on a channel.
- SCAN behaviour:
  - If any pending bit is set, go to EVAL. Pending channels are chosen round-robin, starting after the last evaluated channel.
  - Otherwise, test one PRN per cycle at a pointer that wraps from NUM_PRN-1 to 0. If the PRN is eligible and unassigned, and some channel has been in MODE_IDLE for at least 2 cycles (lowest index wins), go to ASSIGN. If no channel qualifies, the pointer holds.
- EVAL, pass (peak > acq_threshold):
  - ch_mode = MODE_TRACK.
  - ch_init_valid strobes with init_doppler = peak_doppler and init_code_shift = peak_code_shift.
- EVAL, fail:
  - ch_mode = MODE_IDLE.
  - The PRN's assigned bit is cleared.
  - The PRN pointer advances past the failed PRN.
- ASSIGN: set ch_prn, ch_mode = MODE_ACQ, set the PRN's assigned bit, then return to SCAN.
- Lock loss is handled in any state. A channel in MODE_TRACK with ch_lock_lost high goes to MODE_IDLE and its PRN is released. ch_lock_lost on a channel not in MODE_TRACK is ignored.
- When a prn_enable bit drops, the channel owning that PRN (any mode) goes to MODE_IDLE and is released. Its pending bit is discarded.
- enable low:
  - All channels go to MODE_IDLE.
  - All pending and assigned bits clear.
  - The FSM goes to IDLE.
- Simultaneous events: enable low > lock loss / prn disable > EVAL > ASSIGN.

## Timing
- Reset values:
  - ch_mode all MODE_IDLE; ch_prn all 0.
  - ch_init_valid 0; init_doppler 0; init_code_shift 0; prn_assigned 0.
  - FSM IDLE; PRN pointer 0; round-robin pointer 0.
- ch_acq_complete rises at cycle t → pending set at t+1 → EVAL at t+2 → ch_mode/ch_init_valid registered at t+3. This holds when no other channel is pending.
- Each additional pending channel adds 2 cycles (EVAL + return to SCAN).
- Assignment: 2 cycles from a qualifying SCAN hit to ch_mode==MODE_ACQ.
- Lock loss: ch_mode goes to MODE_IDLE 1 cycle after ch_lock_lost is sampled high.
- All outputs are registered.

## Configuration
- ACQ_SCHED_RETRY_LIMIT_EN defined:
  - A per-PRN saturating fail counter increments on a failed EVAL and clears on a pass.
  - A PRN whose count reaches RETRY_LIMIT is parked: SCAN skips it.
  - Park state and counters clear when the PRN's prn_enable bit falls, or when enable falls.
- Macro undefined: no counters; failed PRNs are retried without limit.

## Structure
- The shared header acq_scheduler.vh holds the PRN_WIDTH macro/range and the FSM state encodings.
- MODE_IDLE, MODE_ACQ and MODE_TRACK are reused from channel__acquisition_controller.vh.
- One sub-module, rr_pick: a round-robin one-hot selector over NUM_CH request bits with a registered last-grant pointer.

## Test plan
- NUM_CH=2, prn_enable=0x5 → ch0 gets PRN 0, ch1 gets PRN 2, both MODE_ACQ; prn_assigned=0x5.
- ch0 completes with peak 900, threshold 500, doppler 1598, code shift 7 → ch0 MODE_TRACK at t+3; one ch_init_valid[0] pulse with 1598/7.
- ch1 completes with peak 400, threshold 500 → ch1 MODE_IDLE; PRN 2 released; after ≥2 idle cycles ch1 gets PRN 2 again as MODE_ACQ with an IDLE gap.
- Both channels complete in the same cycle, round-robin pointer at 0 → ch1 evaluated first, ch0 two cycles later.
- ch0 in TRACK, ch_lock_lost[0] pulsed → ch0 MODE_IDLE next cycle; PRN 0 reassigned. Also: global_reset_n low mid-EVAL → all outputs return to reset values immediately.
- ACQ_SCHED_RETRY_LIMIT_EN, RETRY_LIMIT=3, PRN 2 fails 3 times → never reassigned; toggling prn_enable[2] low then high restores it.
